data_mem_arbiter: RTL

Shares the single data memory between two requesters: port 0 is the core load/store path and port 1 is the loader/debug port used to preload or inspect memory. Each cycle it picks at most one winner and drives that request onto the memory command bus. It tracks in-flight reads so each read response is routed back to the port that issued it.

---
 rtl/data_mem_arbiter_pkg.sv | 18 +
 rtl/data_mem_arbiter_rd_return_tracker.sv | 64 ++++++
 rtl/data_mem_arbiter.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/data_mem_arbiter_pkg.sv
// Shared definitions for the data memory arbiter.
//   port_id_e         : identifies which requester owns a request/response
//   READ_LATENCY_MAX  : largest supported memory read latency
//   read_latency_ok() : parameter range check used at elaboration
package data_mem_arbiter_pkg;

    typedef enum logic {
        PORT_CORE   = 1'b0,
        PORT_LOADER = 1'b1
    } port_id_e;

    localparam int READ_LATENCY_MAX = 4;

    function automatic bit read_latency_ok(input int lat);
        return (lat >= 0) && (lat <= READ_LATENCY_MAX);
    endfunction

endpackage

// File: rtl/data_mem_arbiter_rd_return_tracker.sv
// Read return tracker: remembers which port issued each granted read and
// routes mem_rdata back to that port when the memory presents it.
// Ports:
//   clock, reset        : clock and asynchronous active-low reset
//   issue_vld, issue_id : a read was granted this cycle, and to which port
//   mem_rdata           : read data from memory
//   rvalid0/1, rdata0/1 : per-port read response (rdata is 0 when not valid)
module data_mem_arbiter_rd_return_tracker
    import data_mem_arbiter_pkg::*;
#(
    parameter int DATA_W  = 64,
    parameter int LATENCY = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              issue_vld,
    input  logic              issue_id,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1
);

    logic ret_vld;
    logic ret_id;

    if (LATENCY == 0) begin : g_comb
        // Zero-latency memory: the response belongs to the read granted now.
        assign ret_vld = issue_vld;
        assign ret_id  = issue_id;
    end else begin : g_pipe
        // Bit 0 holds the read granted last cycle; bit LATENCY-1 is the one
        // whose data the memory is presenting this cycle.
        logic [LATENCY-1:0] vld_q, vld_d;
        logic [LATENCY-1:0] id_q, id_d;

        always_comb begin
            vld_d = LATENCY'({vld_q, issue_vld});
            id_d  = LATENCY'({id_q, issue_id});
        end

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                vld_q <= '0;
                id_q  <= '0;
            end else begin
                vld_q <= vld_d;
                id_q  <= id_d;
            end
        end

        assign ret_vld = vld_q[LATENCY-1];
        assign ret_id  = id_q[LATENCY-1];
    end

    always_comb begin
        rvalid0 = ret_vld && (ret_id == PORT_CORE);
        rvalid1 = ret_vld && (ret_id == PORT_LOADER);
        rdata0  = rvalid0 ? mem_rdata : '0;
        rdata1  = rvalid1 ? mem_rdata : '0;
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Data memory arbiter: shares one data memory between the core load/store
// port (port 0) and the loader/debug port (port 1).
// Ports:
//   clock, reset                 : clock and asynchronous active-low reset
//   req/we/addr/wdata 0 and 1    : per-port request
//   gnt0/gnt1                    : request accepted this cycle
//   rvalid/rdata 0 and 1         : per-port read response
//   mem_addr/mem_wdata/mem_write/mem_read : command to memory (0 when idle)
//   mem_rdata                    : read data from memory
//
// Handshake: a requester raises req and holds req/we/addr/wdata stable until
// it sees gnt high; the transfer happens on the rising edge where req and gnt
// are both high. Dropping req before a grant is allowed and has no effect.
module data_mem_arbiter
    import data_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 64,
    parameter int DATA_W       = 64,
    parameter int READ_LATENCY = 1,
    parameter int FIXED_PRIO   = 1,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_write,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_rdata
);

    if (!read_latency_ok(READ_LATENCY)) begin : g_bad_latency
        $error("data_mem_arbiter: READ_LATENCY must be within 0..4");
    end

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

    // rr_q names the port that wins the next tie (the one not granted last).
    port_id_e         rr_q, rr_d;
    logic [CNT_W-1:0] starve_q, starve_d;

    logic     win_vld;
    port_id_e win_id;
    logic     win_we;

    always_comb begin
        win_vld   = 1'b0;
        win_id    = PORT_CORE;
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        win_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_write = 1'b0;
        mem_read  = 1'b0;
        rr_d      = rr_q;
        starve_d  = starve_q;

        // No grants while reset is asserted, even if requests are held high.
        if (reset) begin
            if (FIXED_PRIO != 0) begin
                // Port 1 wins when alone or once it has lost STARVE_LIMIT
                // consecutive cycles in a row.
                if (req1 && (!req0 || (starve_q == STARVE_MAX))) begin
                    win_vld = 1'b1;
                    win_id  = PORT_LOADER;
                end else if (req0) begin
                    win_vld = 1'b1;
                    win_id  = PORT_CORE;
                end
            end else begin
                if (req0 && req1) begin
                    win_vld = 1'b1;
                    win_id  = rr_q;
                end else if (req0) begin
                    win_vld = 1'b1;
                    win_id  = PORT_CORE;
                end else if (req1) begin
                    win_vld = 1'b1;
                    win_id  = PORT_LOADER;
                end
            end
        end

        gnt0 = win_vld && (win_id == PORT_CORE);
        gnt1 = win_vld && (win_id == PORT_LOADER);

        if (gnt0) begin
            win_we    = we0;
            mem_addr  = addr0;
            mem_wdata = wdata0;
        end else if (gnt1) begin
            win_we    = we1;
            mem_addr  = addr1;
            mem_wdata = wdata1;
        end
        mem_write = win_vld && win_we;
        mem_read  = win_vld && !win_we;

        if (win_vld) begin
            rr_d = (win_id == PORT_CORE) ? PORT_LOADER : PORT_CORE;
        end

        if (!req1 || gnt1) begin
            starve_d = '0;
        end else if (starve_q != STARVE_MAX) begin
            starve_d = starve_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rr_q     <= PORT_CORE;
            starve_q <= '0;
        end else begin
            rr_q     <= rr_d;
            starve_q <= starve_d;
        end
    end

    data_mem_arbiter_rd_return_tracker #(
        .DATA_W  (DATA_W),
        .LATENCY (READ_LATENCY)
    ) u_rd_return_tracker (
        .clock     (clock),
        .reset     (reset),
        .issue_vld (mem_read),
        .issue_id  (win_id),
        .mem_rdata (mem_rdata),
        .rvalid0   (rvalid0),
        .rvalid1   (rvalid1),
        .rdata0    (rdata0),
        .rdata1    (rdata1)
    );

endmodule
